// File: rtl/temp_meas_ctrl_if.sv
// rtl/temp_meas_ctrl_if.sv - sensor conversion handshake and temperature register-bus signals
interface temp_meas_ctrl_if;
    logic        conv_start;
    logic        conv_done;
    logic [15:0] conv_raw;
    logic        bus_en;
    logic        bus_rs;
    logic        bus_rw;
    logic [7:0]  bus_data;

    modport master (
        output conv_start, bus_en, bus_rs, bus_rw, bus_data,
        input  conv_done, conv_raw
    );

    modport slave (
        input  conv_start, bus_en, bus_rs, bus_rw, bus_data,
        output conv_done, conv_raw
    );
endinterface

// File: rtl/temp_meas_ctrl.sv
// rtl/temp_meas_ctrl.sv - measurement sequencer: trigger, sensor conversion, register-bus write-back
module temp_meas_ctrl #(
    parameter int RAW_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             oneshot,
    input  logic [15:0]      period,
    temp_meas_ctrl_if.master sif,
    output logic             busy,
    output logic [7:0]       meas_cnt,
    output logic             timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {IDLE, START, CONV, AH, DH, AL, DL, AS, DS} state_t;

    state_t           state_q, state_d;
    logic [RAW_W-1:0] raw_q;
    logic [TW-1:0]    tmo_cnt;
    logic [15:0]      per_cnt;
    logic             pending_q, overrun_q, cur_ovr_q, tmo_meas_q;

    logic        per_expire, trigger, tmo_hit;
    logic        conv_start_d, bus_en_d, bus_rs_d;
    logic [7:0]  bus_data_d, status_byte, cnt_inc;
    logic [15:0] per_load;

    assign per_expire  = enable && (per_cnt == 16'd0);
    assign trigger     = oneshot || pending_q || per_expire;
    // Counter runs load..0 inclusive, so load period-1 to get period idle cycles; 0 acts as 1.
    assign per_load    = (period == 16'd0) ? 16'd0 : period - 16'd1;
    assign cnt_inc     = meas_cnt + 8'd1;
    assign status_byte = {cnt_inc[3:0], 1'b0, cur_ovr_q, tmo_meas_q, ~tmo_meas_q};

    always_comb begin
        state_d      = state_q;
        tmo_hit      = 1'b0;
        conv_start_d = 1'b0;
        bus_en_d     = 1'b1;
        bus_rs_d     = 1'b0;
        bus_data_d   = 8'h00;

        case (state_q)
            IDLE:  if (trigger) state_d = START;
            START: state_d = CONV;
            CONV: begin
                if (sif.conv_done) begin
                    state_d = AH;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    state_d = AS;
                    tmo_hit = 1'b1;
                end
            end
            AH:      state_d = DH;
            DH:      state_d = AL;
            AL:      state_d = DL;
            DL:      state_d = AS;
            AS:      state_d = DS;
            DS:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        case (state_d)
            START: begin
                conv_start_d = 1'b1;
                bus_en_d     = 1'b0;
            end
            AH: bus_data_d = 8'h03;
            DH: begin
                bus_rs_d   = 1'b1;
                bus_data_d = raw_q[15:8];
            end
            AL: bus_data_d = 8'h04;
            DL: begin
                bus_rs_d   = 1'b1;
                bus_data_d = raw_q[7:0];
            end
            AS: bus_data_d = 8'h00;
            DS: begin
                bus_rs_d   = 1'b1;
                bus_data_d = status_byte;
            end
            default: bus_en_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            raw_q          <= '0;
            tmo_cnt        <= '0;
            per_cnt        <= '0;
            pending_q      <= 1'b0;
            overrun_q      <= 1'b0;
            cur_ovr_q      <= 1'b0;
            tmo_meas_q     <= 1'b0;
            sif.conv_start <= 1'b0;
            sif.bus_en     <= 1'b0;
            sif.bus_rs     <= 1'b0;
            sif.bus_rw     <= 1'b0;
            sif.bus_data   <= 8'h00;
            busy           <= 1'b0;
            meas_cnt       <= 8'h00;
            timeout_err    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sif.conv_start <= conv_start_d;
            sif.bus_en     <= bus_en_d;
            sif.bus_rs     <= bus_rs_d;
            sif.bus_rw     <= bus_en_d;
            sif.bus_data   <= bus_data_d;
            busy           <= (state_d != IDLE);

            if (state_q == START) begin
                tmo_cnt    <= '0;
                tmo_meas_q <= 1'b0;
            end else if (state_q == CONV) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (state_q == CONV && sif.conv_done) raw_q <= sif.conv_raw;

            if (tmo_hit) begin
                tmo_meas_q  <= 1'b1;
                timeout_err <= 1'b1;
            end

            if (state_q == DS) meas_cnt <= cnt_inc;

            // Overrun only ever accompanies a pending request, so it is reported by the run that services it.
            if (state_q == IDLE) begin
                if (trigger) begin
                    cur_ovr_q <= overrun_q;
                    pending_q <= 1'b0;
                    overrun_q <= 1'b0;
                end
            end else if (oneshot) begin
                if (pending_q) overrun_q <= 1'b1;
                else           pending_q <= 1'b1;
            end

            if (!enable) begin
                per_cnt <= 16'd0;
            end else if (state_q != IDLE && state_d == IDLE) begin
                per_cnt <= per_load;
            end else if (state_q == IDLE && per_cnt != 16'd0) begin
                per_cnt <= per_cnt - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_temp_meas_ctrl.sv
// tb/tb_temp_meas_ctrl.sv - scoreboard bench for temp_meas_ctrl
module tb_temp_meas_ctrl;
    localparam int TIMEOUT = 1024;
    localparam int PERIOD  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        oneshot;
    logic [15:0] period;
    logic        busy;
    logic [7:0]  meas_cnt;
    logic        timeout_err;

    temp_meas_ctrl_if sif ();

    temp_meas_ctrl #(.RAW_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .oneshot     (oneshot),
        .period      (period),
        .sif         (sif),
        .busy        (busy),
        .meas_cnt    (meas_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          start_cyc[$];
    int          n_checks    = 0;
    int          n_errors    = 0;
    int          exp_cnt     = 0;
    int          conv_pulses = 0;
    int          cyc         = 0;
    int          sens_delay  = 1;
    logic [15:0] sens_raw    = 16'h0000;
    bit          sens_mute   = 1'b0;
    bit          done;
    int          base;
    int          sc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Bus monitor: every write is popped against the scoreboard, idle bus must be all zero.
    always @(negedge clk) begin
        if (sif.conv_start) begin
            conv_pulses++;
            start_cyc.push_back(cyc);
        end
        if (sif.bus_en) begin
            if (exp_q.size() == 0) begin
                check("bus_unexpected_write", 32'(sif.bus_data), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("bus_rs", 32'(sif.bus_rs), 32'(mon_e.rs));
                check("bus_rw", 32'(sif.bus_rw), 32'd1);
                check("bus_data", 32'(sif.bus_data), 32'(mon_e.data));
            end
        end else begin
            check("bus_quiet", 32'({sif.bus_rs, sif.bus_rw, sif.bus_data}), 32'd0);
        end
    end

    // Sensor model: answers conv_start after sens_delay cycles and checks write-back latency.
    initial begin
        sif.conv_done = 1'b0;
        sif.conv_raw  = 16'h0000;
        forever begin
            @(negedge clk);
            if (sif.conv_start && !sens_mute) begin
                repeat (sens_delay) @(negedge clk);
                sif.conv_done = 1'b1;
                sif.conv_raw  = sens_raw;
                @(negedge clk);
                sif.conv_done = 1'b0;
                check("lat_bus_en", 32'(sif.bus_en), 32'd1);
                repeat (6) @(negedge clk);
                check("lat_busy_low", 32'(busy), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_meas(input logic [15:0] raw, input bit tmo, input bit ovr);
        logic [7:0] nxt;
        nxt = 8'(exp_cnt + 1);
        if (!tmo) begin
            exp_q.push_back({1'b0, 8'h03});
            exp_q.push_back({1'b1, raw[15:8]});
            exp_q.push_back({1'b0, 8'h04});
            exp_q.push_back({1'b1, raw[7:0]});
        end
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, nxt[3:0], 1'b0, ovr, tmo, ~tmo});
        exp_cnt++;
    endtask

    task automatic fire_oneshot(input string tag);
        oneshot = 1'b1;
        @(negedge clk);
        oneshot = 1'b0;
        check({tag, "_conv_start"}, 32'(sif.conv_start), 32'd1);
    endtask

    task automatic pulse_oneshot();
        oneshot = 1'b1;
        @(negedge clk);
        oneshot = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_complete"}, 32'(ok), 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        oneshot = 1'b0;
        period  = 16'(PERIOD);
        tick(3);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus_en", 32'(sif.bus_en), 32'd0);
        check("rst_conv_start", 32'(sif.conv_start), 32'd0);
        check("rst_meas_cnt", 32'(meas_cnt), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_bus_data", 32'(sif.bus_data), 32'd0);
        tick(2);

        // Single oneshot, conversion finishes 5 cycles after conv_start.
        sens_delay = 5;
        sens_raw   = 16'h1234;
        push_meas(16'h1234, 1'b0, 1'b0);
        fire_oneshot("basic");
        wait_idle("basic", 50);
        check("basic_meas_cnt", 32'(meas_cnt), 32'd1);
        check("basic_timeout_err", 32'(timeout_err), 32'd0);

        // Oneshot in the same IDLE cycle as period expiry: one run, no overrun.
        period   = 16'd5;
        sens_raw = 16'hA55A;
        push_meas(16'hA55A, 1'b0, 1'b0);
        base    = conv_pulses;
        enable  = 1'b1;
        oneshot = 1'b1;
        @(negedge clk);
        oneshot = 1'b0;
        enable  = 1'b0;
        check("coinc_conv_start", 32'(sif.conv_start), 32'd1);
        wait_idle("coinc", 50);
        tick(20);
        check("coinc_single_run", 32'(conv_pulses - base), 32'd1);

        // Periodic mode: 256 runs, equal spacing, meas_cnt wraps through 0xFF.
        sens_delay = 1;
        sens_raw   = 16'h5AC3;
        period     = 16'(PERIOD);
        for (int k = 0; k < 256; k++) push_meas(16'h5AC3, 1'b0, 1'b0);
        base   = conv_pulses;
        sc     = start_cyc.size();
        done   = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (conv_pulses >= base + 256) begin
                done = 1'b1;
                break;
            end
        end
        enable = 1'b0;
        check("periodic_runs", 32'(done), 32'd1);
        wait_idle("periodic", 50);
        tick(30);
        check("periodic_count", 32'(conv_pulses - base), 32'd256);
        check("periodic_meas_cnt", 32'(meas_cnt), 32'(exp_cnt & 255));
        for (int k = sc + 1; k < sc + 256 && k < start_cyc.size(); k++)
            check("periodic_spacing", 32'(start_cyc[k] - start_cyc[k-1]), 32'(PERIOD + 8));

        // Conversion timeout right after a reset: only AS/DS writes, status 0x12.
        rst = 1'b1;
        tick(1);
        rst     = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
        check("tmo_pre_err", 32'(timeout_err), 32'd0);
        sens_mute = 1'b1;
        push_meas(16'h0000, 1'b1, 1'b0);
        fire_oneshot("tmo");
        tick(TIMEOUT);
        check("tmo_last_conv_bus_en", 32'(sif.bus_en), 32'd0);
        check("tmo_last_conv_err", 32'(timeout_err), 32'd0);
        tick(1);
        check("tmo_first_write", 32'(sif.bus_en), 32'd1);
        wait_idle("tmo", 20);
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);
        check("tmo_meas_cnt", 32'(meas_cnt), 32'd1);
        sens_mute = 1'b0;

        // Three oneshots while converting: one extra run flagged overrun, next run clean.
        sens_delay = 20;
        sens_raw   = 16'hC0DE;
        push_meas(16'hC0DE, 1'b0, 1'b0);
        push_meas(16'hC0DE, 1'b0, 1'b1);
        base = conv_pulses;
        fire_oneshot("ovr");
        tick(3);
        pulse_oneshot();
        tick(2);
        pulse_oneshot();
        tick(2);
        pulse_oneshot();
        wait_idle("ovr", 120);
        tick(10);
        check("ovr_extra_runs", 32'(conv_pulses - base), 32'd2);
        push_meas(16'hC0DE, 1'b0, 1'b0);
        fire_oneshot("ovr_after");
        wait_idle("ovr_after", 60);
        check("ovr_meas_cnt", 32'(meas_cnt), 32'(exp_cnt & 255));

        // Reset during DH aborts the sequence; a fresh oneshot then runs normally.
        sens_delay = 3;
        sens_raw   = 16'hBEEF;
        exp_q.push_back({1'b0, 8'h03});
        exp_q.push_back({1'b1, 8'hBE});
        fire_oneshot("abort");
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sif.bus_en && sif.bus_rs) begin
                done = 1'b1;
                break;
            end
        end
        check("abort_reached_dh", 32'(done), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_bus_en", 32'(sif.bus_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_meas_cnt", 32'(meas_cnt), 32'd0);
        exp_cnt = 0;
        tick(10);
        check("abort_no_more_writes", 32'(exp_q.size()), 32'd0);
        push_meas(16'hBEEF, 1'b0, 1'b0);
        fire_oneshot("fresh");
        wait_idle("fresh", 50);
        check("fresh_meas_cnt", 32'(meas_cnt), 32'd1);

        tick(5);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/temp_meas_ctrl.md
TEMP_MEAS_CTRL -- requirements
Module: temp_meas_ctrl

Interface
REQ-001 Parameter RAW_W, default 16: width of raw conversion result; fixed at 16, split into RAWH/RAWL bytes.
REQ-002 Parameter TIMEOUT, default 1024: cycles allowed in CONV before a timeout is declared.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  continuous-mode enable; periodic measurements while high.
REQ-006 oneshot  input  1  single-cycle request for one measurement.
REQ-007 period  input  16  cycles between periodic triggers.
REQ-008 conv_start  output  1  one-cycle pulse starting the sensor conversion.
REQ-009 conv_done  input  1  sensor result valid, sampled only in CONV.
REQ-010 conv_raw  input  16  raw result, captured on the conv_done cycle.
REQ-011 bus_en, bus_rs, bus_rw  output  1 each  register-bus strobes to the temperature interface.
REQ-012 bus_data  output  8  register-bus write data (address or value).
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 meas_cnt  output  8  completed-measurement counter.
REQ-015 timeout_err  output  1  sticky; set on timeout, cleared only by rst.

Function
REQ-016 FSM states: IDLE, START, CONV, AH, DH, AL, DL, AS, DS; all outputs registered.
REQ-017 IDLE -> START on trigger: oneshot, pending flag, or period counter expiry with enable=1.
REQ-018 START: conv_start=1 for exactly one cycle; next state CONV; timeout counter cleared.
REQ-019 CONV: on conv_done=1, capture conv_raw and go to AH; conv_done outside CONV is ignored.
REQ-020 CONV: after TIMEOUT cycles without conv_done, set timeout_err and go to AS, skipping raw writes.
REQ-021 Each bus state drives bus_en=1 for one cycle; address states use rs=0,rw=1; data states use rs=1,rw=1.
REQ-022 AH data 0x03; DH data raw[15:8]; AL data 0x04; DL data raw[7:0]; AS data 0x00; DS data status byte.
REQ-023 Status byte: bit0 valid (1 = raw written), bit1 timeout this measurement, bit2 overrun, bit3 0, bits7:4 = (meas_cnt+1)[3:0].
REQ-024 DS -> IDLE; meas_cnt increments by 1 on leaving DS, wraps 0xFF -> 0x00, and increments on timeout measurements too.
REQ-025 When bus_en=0: bus_rs=0, bus_rw=0, bus_data=0x00.
REQ-026 Latency: trigger seen in IDLE at cycle T -> conv_start at T+1; conv_done at cycle C -> bus_en at C+1..C+6; busy low at C+7.
REQ-027 Period counter: loads period on entering IDLE, counts down only in IDLE with enable=1; expiry at 0; period=0 behaves as 1.
REQ-028 enable falling clears the period counter; an in-flight measurement completes normally.
REQ-029 Trigger while busy: sets pending (one deep); further triggers while pending set the overrun flag for the next status byte.
REQ-030 Pending is serviced on the IDLE cycle after DS; overrun is cleared when its status byte is written.
REQ-031 oneshot and period expiry in the same IDLE cycle produce exactly one measurement, with no overrun.

Reset
REQ-032 rst=1 at any edge: state IDLE; conv_start, bus_en, bus_rs, bus_rw, busy, timeout_err = 0; bus_data=0x00; meas_cnt=0; pending, overrun, raw register and counters cleared.
REQ-033 rst mid-bus-sequence aborts with no further bus_en pulses; the partially written register set is not repaired.

Verification
REQ-034 oneshot, conv_done 5 cycles after conv_start with raw 0x1234 -> bus writes 03,12,04,34,00,11; meas_cnt=1.
REQ-035 enable=1, period=10, immediate conv_done -> conv_start pulses equally spaced; meas_cnt wraps 0xFF -> 0x00 after 256 runs.
REQ-036 oneshot with no conv_done -> after 1024 cycles, timeout_err=1; writes only 00 then status 0x12; meas_cnt=1.
REQ-037 Three oneshots during CONV -> one extra measurement runs; its status has bit2=1 and the following status has bit2=0.
REQ-038 rst asserted in DH -> next cycle bus_en=0, busy=0, meas_cnt=0; a fresh oneshot then completes normally.
REQ-039 oneshot coincident with period expiry -> single conv_start; status bit2=0.
